// File: rtl/fp_to_twos_decoder_if.sv
// Handshake bundle for the compact-float to two's-complement decoder.
// Carries the input float {S, E, F} with in_valid/in_ready and the result D with out_valid/out_ready.
// master: drives the float and consumes D; slave: the decoder itself.
interface fp_to_twos_decoder_if #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4,
  parameter int OUT_W  = 12
);
  logic              in_valid;
  logic              in_ready;
  logic              S;
  logic [EXP_W-1:0]  E;
  logic [FRAC_W-1:0] F;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  D;

  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D
  );

  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D
  );
endinterface

// File: rtl/fp_to_twos_decoder.sv
// Purpose: expand a compact float {S, E, F} to a two's-complement word D = (S ? -1 : 1) * F * 2^E.
// Latency: out_valid rises E+2 clocks after the accept edge (2..9); one shift per cycle, no barrel shifter.
// Backpressure: in_ready only in IDLE, no input buffering; D held in DONE until out_ready.
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport of fp_to_twos_decoder_if):
//   in_valid/in_ready/S/E/F on the input side, out_valid/out_ready/D on the output side.
// Build option: FPDEC_MIDPOINT_EN adds half an LSB of the exponent's step (1 << (E-1)) before
//   the sign is applied, rebuilding the centre of the encoder's rounding interval.
// OUT_W must be at least FRAC_W + 2**EXP_W so the largest magnitude never overflows; no saturation.
module fp_to_twos_decoder #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4,
  parameter int OUT_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  fp_to_twos_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [EXP_W-1:0] CNT_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [OUT_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] m;

`ifdef FPDEC_MIDPOINT_EN
  localparam logic [OUT_W-1:0] MID_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [EXP_W-1:0] e_q, e_d;
  logic [OUT_W-1:0] mid;

  // E=0 has no lower bit to round, so no midpoint offset.
  assign mid = (e_q == '0) ? '0 : (MID_ONE << (e_q - CNT_ONE));
  assign m   = mag_q + mid;
`else
  assign m   = mag_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; rst wins in every state and drops any in-flight value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q       <= '0;
      cnt_q       <= '0;
      s_q         <= 1'b0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef FPDEC_MIDPOINT_EN
      e_q         <= '0;
`endif
    end else begin
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
`ifdef FPDEC_MIDPOINT_EN
      e_q         <= e_d;
`endif
    end
  end

  // Next-state and next-datapath logic. S/E/F are only looked at under an
  // accept, so undriven inputs between transfers never reach state.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
`ifdef FPDEC_MIDPOINT_EN
    e_d         = e_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.S;
          mag_d   = OUT_W'(bus.F);
          cnt_d   = bus.E;
`ifdef FPDEC_MIDPOINT_EN
          e_d     = bus.E;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        // Negating a zero magnitude yields zero, so there is no -0 output.
        d_d         = s_q ? (-m) : m;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;

endmodule

// File: tb/tb_fp_to_twos_decoder.sv
// Scoreboard bench for fp_to_twos_decoder: directed vectors push expected D and latency,
// a negedge monitor pops and compares on every output handshake.
// Expected values follow the FPDEC_MIDPOINT_EN build option when it is defined.
module tb_fp_to_twos_decoder;

`ifdef FPDEC_MIDPOINT_EN
  localparam bit MID = 1'b1;
`else
  localparam bit MID = 1'b0;
`endif

  typedef struct {
    logic [11:0] d;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  bit   prev_vld = 1'b0;
  int   first_cyc = 0;

  fp_to_twos_decoder_if #(.EXP_W(3), .FRAC_W(4), .OUT_W(12)) bus ();

  fp_to_twos_decoder #(.EXP_W(3), .FRAC_W(4), .OUT_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: decoupled from stimulus, compares on each out_valid & out_ready.
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.out_valid && !prev_vld) first_cyc = cyc;
      prev_vld = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got D=%0h, expected no output", bus.D);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("D_value", 32'(bus.D), 32'(e.d));
          check("latency", 32'(first_cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  // Drives one float; the accept edge is the posedge after in_valid rises.
  task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f,
                      input logic [11:0] d_exp, input bit push);
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.in_ready) break;
    end
    if (k == 40) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.S = s;
    bus.E = e;
    bus.F = f;
    @(posedge clk); #1;
    if (push) sb.push_back('{d: d_exp, lat: int'(e) + 2, acc: cyc});
    // Junk on S/E/F while not accepting must not leak into the result.
    bus.in_valid = 1'b0;
    bus.S = 1'($urandom);
    bus.E = 3'($urandom);
    bus.F = 4'($urandom);
  endtask

  task automatic wait_vld();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    if (k == 20) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.in_ready && !bus.out_valid && sb.size() == 0) break;
    end
    if (k == 40) check("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.S         = 1'b0;
    bus.E         = '0;
    bus.F         = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_D", 32'(bus.D), 32'd0);
    rst = 1'b0;

    // 1: smallest latency, E=0.
    send(1'b0, 3'd0, 4'd5, 12'h005, 1'b1);
    wait_idle();

    // 2: largest magnitude, negative; in_ready back right after handoff.
    send(1'b1, 3'd7, 4'd15, MID ? 12'h840 : 12'h880, 1'b1);
    wait_vld();
    @(posedge clk); #1;
    check("t2_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("t2_out_valid_after", 32'(bus.out_valid), 32'd0);
    wait_idle();

    // 3: negative zero collapses to zero (midpoint build yields -4).
    send(1'b1, 3'd3, 4'd0, MID ? 12'hFFC : 12'h000, 1'b1);
    wait_idle();

    // 4: consumer stall in DONE; a second in_valid pulse is ignored.
    bus.out_ready = 1'b0;
    send(1'b0, 3'd2, 4'd3, MID ? 12'h00E : 12'h00C, 1'b1);
    wait_vld();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_D", 32'(bus.D), MID ? 32'h00E : 32'h00C);
      check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.S = 1'b0;
        bus.E = 3'd1;
        bus.F = 4'd1;
      end
      if (i == 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // 5: reset in the middle of SHIFT discards the value.
    send(1'b0, 3'd6, 4'd9, 12'h000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_D", 32'(bus.D), 32'd0);
    check("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    send(1'b1, 3'd1, 4'd3, MID ? 12'hFF9 : 12'hFFA, 1'b1);
    wait_idle();

    // 6: midpoint-sensitive vector.
    send(1'b0, 3'd4, 4'd9, MID ? 12'h098 : 12'h090, 1'b1);
    wait_idle();

    // Further directed patterns.
    send(1'b1, 3'd0, 4'd1, 12'hFFF, 1'b1);
    wait_idle();
    send(1'b0, 3'd5, 4'd1, MID ? 12'h030 : 12'h020, 1'b1);
    wait_idle();
    send(1'b1, 3'd2, 4'd7, MID ? 12'hFE2 : 12'hFE4, 1'b1);
    wait_idle();
    send(1'b0, 3'd7, 4'd15, MID ? 12'h7C0 : 12'h780, 1'b1);
    wait_idle();
    send(1'b1, 3'd6, 4'd1, MID ? 12'hFA0 : 12'hFC0, 1'b1);
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
